// File: rtl/bsg_dramsim3_pkg.sv
// rtl/bsg_dramsim3_pkg.sv - shared FSM state and read-table entry types for the request arbiter
`ifndef BSG_DRAMSIM3_PKG_SV
`define BSG_DRAMSIM3_PKG_SV

// The entry widths depend on module parameters, so the struct is stamped out where it is used.
`define BSG_DRAMSIM3_READ_ENTRY_S(addr_width_mp, id_width_mp) \
  typedef struct packed { \
    logic                     v; \
    logic [addr_width_mp-1:0] addr; \
    logic [id_width_mp-1:0]   id; \
  } bsg_dramsim3_read_entry_s

package bsg_dramsim3_pkg;

  typedef enum logic [0:0] {
    eIdle  = 1'b0,
    eIssue = 1'b1
  } arb_state_e;

endpackage

`endif

// File: rtl/bsg_dramsim3_req_arbiter_if.sv
// rtl/bsg_dramsim3_req_arbiter_if.sv - requester, channel and response signals of the request arbiter
interface bsg_dramsim3_req_arbiter_if
  import bsg_dramsim3_pkg::*;
#(
  parameter int num_req_p            = 4,
  parameter int channel_addr_width_p = 16,
  parameter int data_width_p         = 32
);
  localparam int mask_width_lp = data_width_p / 8;

  logic [num_req_p-1:0]                           req_v_i;
  logic [num_req_p-1:0]                           req_write_not_read_i;
  logic [num_req_p-1:0][channel_addr_width_p-1:0] req_addr_i;
  logic [num_req_p-1:0][data_width_p-1:0]         req_data_i;
  logic [num_req_p-1:0][mask_width_lp-1:0]        req_mask_i;
  logic [num_req_p-1:0]                           req_yumi_o;

  logic                            ch_v_o;
  logic                            ch_write_not_read_o;
  logic                            ch_data_v_o;
  logic [channel_addr_width_p-1:0] ch_addr_o;
  logic [data_width_p-1:0]         ch_data_o;
  logic [mask_width_lp-1:0]        ch_mask_o;
  logic                            ch_yumi_i;

  logic                            ch_data_v_i;
  logic [data_width_p-1:0]         ch_data_i;
  logic [channel_addr_width_p-1:0] ch_read_done_addr_i;

  logic [num_req_p-1:0]            resp_v_o;
  logic [data_width_p-1:0]         resp_data_o;
  logic [channel_addr_width_p-1:0] resp_addr_o;
  logic                            unmatched_o;

  modport slave (
    input  req_v_i, req_write_not_read_i, req_addr_i, req_data_i, req_mask_i,
    output req_yumi_o,
    output ch_v_o, ch_write_not_read_o, ch_data_v_o, ch_addr_o, ch_data_o, ch_mask_o,
    input  ch_yumi_i, ch_data_v_i, ch_data_i, ch_read_done_addr_i,
    output resp_v_o, resp_data_o, resp_addr_o, unmatched_o
  );

  modport master (
    output req_v_i, req_write_not_read_i, req_addr_i, req_data_i, req_mask_i,
    input  req_yumi_o,
    input  ch_v_o, ch_write_not_read_o, ch_data_v_o, ch_addr_o, ch_data_o, ch_mask_o,
    output ch_yumi_i, ch_data_v_i, ch_data_i, ch_read_done_addr_i,
    input  resp_v_o, resp_data_o, resp_addr_o, unmatched_o
  );

endinterface

// File: rtl/bsg_arb_round_robin.sv
// rtl/bsg_arb_round_robin.sv - combinational round-robin pick starting at ptr_i
module bsg_arb_round_robin
  import bsg_dramsim3_pkg::*;
#(
  parameter  int width_p     = 4,
  localparam int lg_width_lp = $clog2(width_p)
) (
  input  logic [width_p-1:0]     reqs_i,
  input  logic [lg_width_lp-1:0] ptr_i,
  output logic                   v_o,
  output logic [lg_width_lp-1:0] grant_id_o
);

  int idx;

  // Scan farthest-to-nearest so the requester closest to ptr_i is the last one written.
  always_comb begin
    v_o        = 1'b0;
    grant_id_o = '0;
    idx        = 0;
    for (int i = width_p - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= width_p) idx = idx - width_p;
      if (reqs_i[lg_width_lp'(idx)]) begin
        v_o        = 1'b1;
        grant_id_o = lg_width_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bsg_dramsim3_req_arbiter.sv
// rtl/bsg_dramsim3_req_arbiter.sv - round-robin arbiter of N requesters onto one dramsim3 channel
// with an outstanding-read table that routes read returns back to their requester.
module bsg_dramsim3_req_arbiter
  import bsg_dramsim3_pkg::*;
#(
  parameter int num_req_p            = 4,
  parameter int channel_addr_width_p = 16,
  parameter int data_width_p         = 32,
  parameter int read_table_els_p     = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  bsg_dramsim3_req_arbiter_if.slave  io
);

  localparam int lg_req_lp      = $clog2(num_req_p);
  localparam int lg_els_lp      = (read_table_els_p > 1) ? $clog2(read_table_els_p) : 1;
  localparam int count_width_lp = $clog2(read_table_els_p + 1);

  `BSG_DRAMSIM3_READ_ENTRY_S(channel_addr_width_p, lg_req_lp);

  arb_state_e                  state_q, state_d;
  logic [lg_req_lp-1:0]        rr_ptr_q, rr_ptr_d;
  logic [lg_req_lp-1:0]        winner_q, winner_d;
  logic [count_width_lp-1:0]   count_q, count_d;
  bsg_dramsim3_read_entry_s    table_q [read_table_els_p];
  bsg_dramsim3_read_entry_s    table_d [read_table_els_p];

  logic                        table_full;
  logic [num_req_p-1:0]        hazard, eligible;
  logic                        arb_v;
  logic [lg_req_lp-1:0]        arb_id;
  logic [read_table_els_p-1:0] match;
  logic                        match_v;
  logic [lg_req_lp-1:0]        match_id;
  logic [lg_els_lp-1:0]        alloc_idx;
  logic                        alloc, issue;

  assign table_full = (count_q == count_width_lp'(read_table_els_p));

  // Reads wait while the table is full or their address is already in flight, so at most
  // one table entry can ever match a given return address.
  always_comb begin
    hazard   = '0;
    eligible = '0;
    for (int r = 0; r < num_req_p; r++) begin
      for (int e = 0; e < read_table_els_p; e++) begin
        if (table_q[e].v && (table_q[e].addr == io.req_addr_i[r])) hazard[r] = 1'b1;
      end
      eligible[r] = io.req_v_i[r] & (io.req_write_not_read_i[r] | ~(table_full | hazard[r]));
    end
  end

  bsg_arb_round_robin #(.width_p(num_req_p)) rr_arb (
    .reqs_i     (eligible),
    .ptr_i      (rr_ptr_q),
    .v_o        (arb_v),
    .grant_id_o (arb_id)
  );

  always_comb begin
    match    = '0;
    match_id = '0;
    for (int e = 0; e < read_table_els_p; e++) begin
      match[e] = io.ch_data_v_i & table_q[e].v & (table_q[e].addr == io.ch_read_done_addr_i);
      if (match[e]) match_id = match_id | table_q[e].id;
    end
  end
  assign match_v = |match;

  always_comb begin
    alloc_idx = '0;
    for (int e = read_table_els_p - 1; e >= 0; e--) begin
      if (!table_q[e].v) alloc_idx = lg_els_lp'(e);
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    alloc    = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      eIdle: begin
        if (arb_v) begin
          winner_d = arb_id;
          state_d  = eIssue;
        end
      end
      eIssue: begin
        issue = 1'b1;
        if (io.ch_yumi_i) begin
          rr_ptr_d = (winner_q == lg_req_lp'(num_req_p - 1)) ? '0 : winner_q + lg_req_lp'(1);
          alloc    = ~io.req_write_not_read_i[winner_q];
          state_d  = eIdle;
        end
      end
      default: state_d = eIdle;
    endcase
  end

  // The freed entry still reads valid in table_q, so alloc_idx never lands on it this cycle.
  always_comb begin
    table_d = table_q;
    for (int e = 0; e < read_table_els_p; e++) begin
      if (match[e]) table_d[e].v = 1'b0;
    end
    if (alloc) begin
      table_d[alloc_idx].v    = 1'b1;
      table_d[alloc_idx].addr = io.req_addr_i[winner_q];
      table_d[alloc_idx].id   = winner_q;
    end
  end

  assign count_d = count_q + count_width_lp'(alloc) - count_width_lp'(match_v);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= eIdle;
      rr_ptr_q <= '0;
      winner_q <= '0;
      count_q  <= '0;
      for (int e = 0; e < read_table_els_p; e++) table_q[e] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      count_q  <= count_d;
      table_q  <= table_d;
    end
  end

  assign io.ch_v_o              = issue & ~reset_i;
  assign io.ch_write_not_read_o = io.req_write_not_read_i[winner_q];
  assign io.ch_data_v_o         = issue & ~reset_i & io.req_write_not_read_i[winner_q];
  assign io.ch_addr_o           = io.req_addr_i[winner_q];
  assign io.ch_data_o           = io.req_data_i[winner_q];
  assign io.ch_mask_o           = io.req_mask_i[winner_q];
  assign io.req_yumi_o          = (issue & io.ch_yumi_i & ~reset_i)
                                  ? (num_req_p'(1) << winner_q) : '0;

  assign io.resp_v_o    = (match_v & ~reset_i) ? (num_req_p'(1) << match_id) : '0;
  assign io.resp_data_o = io.ch_data_i;
  assign io.resp_addr_o = io.ch_read_done_addr_i;
  assign io.unmatched_o = io.ch_data_v_i & ~match_v & ~reset_i;

endmodule

// File: tb/tb_bsg_dramsim3_req_arbiter.sv
// tb/tb_bsg_dramsim3_req_arbiter.sv - directed self-checking bench for bsg_dramsim3_req_arbiter
module tb_bsg_dramsim3_req_arbiter;

  localparam int nr = 4;
  localparam int aw = 16;
  localparam int dw = 32;
  localparam int els = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsg_dramsim3_req_arbiter_if #(.num_req_p(nr), .channel_addr_width_p(aw), .data_width_p(dw)) bus ();

  bsg_dramsim3_req_arbiter #(
    .num_req_p(nr), .channel_addr_width_p(aw), .data_width_p(dw), .read_table_els_p(els)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req_v;
    logic [3:0]  exp_yumi;
    logic        exp_ch_v;
    logic [15:0] exp_addr;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ret(input logic [15:0] a, input logic [31:0] d, input logic [3:0] exp_resp,
                     input logic exp_unm, input string name);
    bus.ch_data_v_i         = 1'b1;
    bus.ch_read_done_addr_i = a;
    bus.ch_data_i           = d;
    smp();
    chk({name, ".resp_v"}, bus.resp_v_o, exp_resp);
    chk({name, ".unmatched"}, bus.unmatched_o, exp_unm);
    if (exp_resp != 4'b0) chk({name, ".resp_addr_data"}, {bus.resp_addr_o, bus.resp_data_o}, {a, d});
    cyc();
    bus.ch_data_v_i = 1'b0;
  endtask

  task automatic do_req(input int id, input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input string name);
    int waited;
    bit got;
    waited = 0;
    got    = 1'b0;
    bus.req_v_i[id]              = 1'b1;
    bus.req_write_not_read_i[id] = wr;
    bus.req_addr_i[id]           = a;
    bus.req_data_i[id]           = d;
    bus.req_mask_i[id]           = 4'hF;
    while (!got && waited < 8) begin
      smp();
      got = bus.req_yumi_o[id];
      cyc();
      waited++;
    end
    bus.req_v_i[id] = 1'b0;
    chk({name, ".grant_latency"}, waited, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_w, bad, early, waited;
    bit got;

    vecs[0] = '{4'b1111, 4'b0000, 1'b0, 16'h0000};
    vecs[1] = '{4'b1111, 4'b0001, 1'b1, 16'h0010};
    vecs[2] = '{4'b1110, 4'b0000, 1'b0, 16'h0000};
    vecs[3] = '{4'b1110, 4'b0010, 1'b1, 16'h0020};
    vecs[4] = '{4'b1100, 4'b0000, 1'b0, 16'h0000};
    vecs[5] = '{4'b1100, 4'b0100, 1'b1, 16'h0030};
    vecs[6] = '{4'b1000, 4'b0000, 1'b0, 16'h0000};
    vecs[7] = '{4'b1000, 4'b1000, 1'b1, 16'h0040};

    reset                    = 1'b1;
    bus.req_v_i              = 4'hF;
    bus.req_write_not_read_i = '0;
    bus.req_addr_i           = '0;
    bus.req_data_i           = '0;
    bus.req_mask_i           = '0;
    bus.ch_yumi_i            = 1'b1;
    bus.ch_data_v_i          = 1'b1;
    bus.ch_data_i            = '0;
    bus.ch_read_done_addr_i  = 16'h0123;
    cyc();
    cyc();
    smp();
    chk("reset.outputs", {bus.req_yumi_o, bus.ch_v_o, bus.ch_data_v_o, bus.resp_v_o, bus.unmatched_o}, '0);
    chk("reset.count", dut.count_q, 0);

    // Four reads to distinct addresses, channel always ready.
    cyc();
    reset           = 1'b0;
    bus.ch_data_v_i = 1'b0;
    for (int r = 0; r < nr; r++) bus.req_addr_i[r] = 16'(16 * (r + 1));
    for (int i = 0; i < 8; i++) begin
      bus.req_v_i = vecs[i].req_v;
      smp();
      chk($sformatf("rr%0d.yumi", i), bus.req_yumi_o, vecs[i].exp_yumi);
      chk($sformatf("rr%0d.ch_v", i), bus.ch_v_o, vecs[i].exp_ch_v);
      if (vecs[i].exp_ch_v) chk($sformatf("rr%0d.ch_addr", i), bus.ch_addr_o, vecs[i].exp_addr);
      cyc();
    end
    bus.req_v_i = '0;
    ret(16'h0040, 32'h0000_00A4, 4'b1000, 1'b0, "rr_ret40");
    ret(16'h0010, 32'h0000_00A1, 4'b0001, 1'b0, "rr_ret10");
    ret(16'h0020, 32'h0000_00A2, 4'b0010, 1'b0, "rr_ret20");
    ret(16'h0030, 32'h0000_00A3, 4'b0100, 1'b0, "rr_ret30");
    chk("rr.count_drained", dut.count_q, 0);

    // Write held by channel backpressure.
    bus.ch_yumi_i               = 1'b0;
    bus.req_v_i[0]              = 1'b1;
    bus.req_write_not_read_i[0] = 1'b1;
    bus.req_addr_i[0]           = 16'h0040;
    bus.req_data_i[0]           = 32'h0000_DEAD;
    bus.req_mask_i[0]           = 4'hF;
    smp();
    chk("hold.idle_ch_v", bus.ch_v_o, 1'b0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      smp();
      chk($sformatf("hold%0d.ch", k),
          {bus.ch_v_o, bus.ch_write_not_read_o, bus.ch_data_v_o, bus.ch_addr_o, bus.ch_data_o,
           bus.ch_mask_o, bus.req_yumi_o},
          {1'b1, 1'b1, 1'b1, 16'h0040, 32'h0000_DEAD, 4'hF, 4'b0000});
      cyc();
    end
    bus.ch_yumi_i = 1'b1;
    smp();
    chk("hold.yumi", {bus.ch_v_o, bus.req_yumi_o}, {1'b1, 4'b0001});
    cyc();
    bus.req_v_i[0]              = 1'b0;
    bus.req_write_not_read_i[0] = 1'b0;
    smp();
    chk("hold.after_ch_v", bus.ch_v_o, 1'b0);
    cyc();

    // Out-of-order returns.
    do_req(1, 1'b0, 16'h0100, 32'h0, "ooo_rd1");
    do_req(2, 1'b0, 16'h0200, 32'h0, "ooo_rd2");
    ret(16'h0200, 32'h2222_2222, 4'b0100, 1'b0, "ooo_ret200");
    ret(16'h0100, 32'h1111_1111, 4'b0010, 1'b0, "ooo_ret100");

    // Table full: a 9th read waits while a write passes.
    for (int i = 0; i < els; i++) do_req(i % nr, 1'b0, 16'(16'h0300 + 4 * i), 32'h0, "fill");
    chk("full.count", dut.count_q, els);
    bus.req_write_not_read_i[0] = 1'b0;
    bus.req_addr_i[0]           = 16'h0400;
    bus.req_v_i[0]              = 1'b1;
    bus.req_write_not_read_i[1] = 1'b1;
    bus.req_addr_i[1]           = 16'h0500;
    bus.req_v_i[1]              = 1'b1;
    got_w = 0;
    bad   = 0;
    for (int c = 0; c < 6; c++) begin
      smp();
      if (bus.req_yumi_o[1]) got_w++;
      if (bus.req_yumi_o[0]) bad++;
      cyc();
      if (got_w > 0) bus.req_v_i[1] = 1'b0;
    end
    chk("full.write_grants", got_w, 1);
    chk("full.read_blocked", bad, 0);
    bus.req_write_not_read_i[1] = 1'b0;
    ret(16'h0300, 32'h3000_0000, 4'b0001, 1'b0, "full_ret300");
    smp();
    chk("full.arb_cycle_ch_v", bus.ch_v_o, 1'b0);
    cyc();
    smp();
    chk("full.read9_issue", {bus.req_yumi_o, bus.ch_addr_o}, {4'b0001, 16'h0400});
    cyc();
    bus.req_v_i[0] = 1'b0;
    for (int i = 1; i < els; i++)
      ret(16'(16'h0300 + 4 * i), 32'(i), 4'(1 << (i % nr)), 1'b0, "drain");
    ret(16'h0400, 32'h0400_0400, 4'b0001, 1'b0, "drain400");
    chk("drain.count", dut.count_q, 0);

    // Address hazard stall and unmatched return.
    do_req(0, 1'b0, 16'h0080, 32'h0, "haz_rd0");
    bus.req_write_not_read_i[3] = 1'b0;
    bus.req_addr_i[3]           = 16'h0080;
    bus.req_v_i[3]              = 1'b1;
    early = 0;
    for (int c = 0; c < 4; c++) begin
      smp();
      if (bus.req_yumi_o[3]) early++;
      cyc();
    end
    chk("haz.stalled", early, 0);
    ret(16'h0080, 32'h8080_8080, 4'b0001, 1'b0, "haz_ret0");
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 6) begin
      smp();
      got = bus.req_yumi_o[3];
      cyc();
      waited++;
    end
    bus.req_v_i[3] = 1'b0;
    chk("haz.release_latency", waited, 2);
    ret(16'h0080, 32'h8181_8181, 4'b1000, 1'b0, "haz_ret3");
    ret(16'h0999, 32'h0, 4'b0000, 1'b1, "unm_999");
    smp();
    chk("unm.single_pulse", bus.unmatched_o, 1'b0);
    cyc();

    // Reset with reads outstanding and a request stuck in issue.
    do_req(0, 1'b0, 16'h00A0, 32'h0, "rst_rd0");
    do_req(1, 1'b0, 16'h00B0, 32'h0, "rst_rd1");
    do_req(2, 1'b0, 16'h00C0, 32'h0, "rst_rd2");
    bus.ch_yumi_i      = 1'b0;
    bus.req_addr_i[3]  = 16'h00D0;
    bus.req_v_i[3]     = 1'b1;
    cyc();
    smp();
    chk("rst.pre_ch_v", bus.ch_v_o, 1'b1);
    cyc();
    reset                   = 1'b1;
    bus.ch_yumi_i           = 1'b1;
    bus.ch_data_v_i         = 1'b1;
    bus.ch_read_done_addr_i = 16'h00A0;
    smp();
    chk("rst.outputs", {bus.req_yumi_o, bus.ch_v_o, bus.ch_data_v_o, bus.resp_v_o, bus.unmatched_o}, '0);
    cyc();
    smp();
    chk("rst.count", dut.count_q, 0);
    cyc();
    reset           = 1'b0;
    bus.ch_data_v_i = 1'b0;
    bus.req_v_i     = '0;
    ret(16'h00A0, 32'hA0, 4'b0000, 1'b1, "late_A0");
    ret(16'h00B0, 32'hB0, 4'b0000, 1'b1, "late_B0");
    ret(16'h00C0, 32'hC0, 4'b0000, 1'b1, "late_C0");
    smp();
    chk("post_rst.ch_v", bus.ch_v_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
